aib_link_supervisor: RTL and testbench

Supervises the AIB calibration master sequencer and the AXI-Lite traffic that rides on the link. Owns the sequencer's reset and times out calibration attempts, retrying them up to a bound. Monitors the per-channel transfer-enable status while the link is up and triggers recalibration on a drop. Gates AXI-Lite traffic so that nothing is issued unless the link is up, and drains outstanding transactions before a software-requested recalibration.

---
 rtl/aib_link_pkg.sv | 40 ++++
 rtl/aib_cycle_timer.sv | 34 +++
 rtl/aib_link_supervisor.sv | 161 ++++++++++++++++
 tb/tb_aib_link_supervisor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/aib_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aib_link_pkg
// Description : Shared types, defaults and helpers for the AIB link
//               supervisor.
// Revision    : 1.0 - initial release
// ============================================================================
package aib_link_pkg;

  // Supervisor states, in bring-up order.
  typedef enum logic [2:0] {
    OFF      = 3'd0,
    HOLD_RST = 3'd1,
    CALIB    = 3'd2,
    UP       = 3'd3,
    DRAIN    = 3'd4,
    FAIL     = 3'd5
  } link_state_t;

  localparam int DEF_TIMEOUT_CYCLES  = 4096;
  localparam int DEF_RST_HOLD_CYCLES = 16;
  localparam int DEF_MAX_RETRY       = 3;

  // Widest channel vector the reduction helper accepts.
  localparam int CHNL_MAX = 256;

  // True when the low n bits of v are all ones. Bits above n are ignored,
  // so callers can pass a zero-extended vector of any width up to CHNL_MAX.
  function automatic logic all_ones(input logic [CHNL_MAX-1:0] v,
                                    input int unsigned n);
    logic r;
    r = 1'b1;
    for (int i = 0; i < CHNL_MAX; i++) begin
      if (i < n) r = r & v[i];
    end
    return r;
  endfunction

endpackage : aib_link_pkg
`default_nettype wire

// File: rtl/aib_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : aib_cycle_timer
// Description : Loadable up-counter with clear, enable and a terminal-count
//               compare against a run-time selectable value.
// Revision    : 1.0 - initial release
// ============================================================================
module aib_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] tc_val,
  output logic             tc_hit
);

  logic [WIDTH-1:0] r_count;

  // Clear has priority over load, load over count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_count <= '0;
    else if (clr)  r_count <= '0;
    else if (load) r_count <= load_val;
    else if (en)   r_count <= r_count + 1'b1;
  end

  assign tc_hit = (r_count == tc_val);

endmodule : aib_cycle_timer
`default_nettype wire

// File: rtl/aib_link_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : aib_link_supervisor
// Description : Owns the AIB calibration sequencer reset, times out and
//               retries calibration, watches transfer-enable health while the
//               link is up and gates AXI-Lite traffic accordingly.
// Revision    : 1.0 - initial release
// ============================================================================
module aib_link_supervisor
  import aib_link_pkg::*;
#(
  parameter int TOTAL_CHNL_NUM  = 24,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int MAX_RETRY       = DEF_MAX_RETRY
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      link_en,
  input  logic                      recal_req_i,
  input  logic                      calib_done_i,
  input  logic [TOTAL_CHNL_NUM-1:0] sl_tx_transfer_en,
  input  logic [TOTAL_CHNL_NUM-1:0] sl_rx_transfer_en,
  input  logic                      axi_idle_i,
  output logic                      calib_rstn_o,
  output logic                      axi_gate_o,
  output logic                      link_up,
  output logic                      link_fail,
  output logic [((MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1)-1:0] retry_cnt,
  output logic [7:0]                drop_cnt
);

  localparam int TMAX = (TIMEOUT_CYCLES > RST_HOLD_CYCLES) ? TIMEOUT_CYCLES
                                                           : RST_HOLD_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] C_HOLD_LAST  = TW'(RST_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] C_CALIB_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] C_MAX_RETRY  = RW'(MAX_RETRY);

  link_state_t   r_state;
  link_state_t   w_state_nxt;
  logic [RW-1:0] w_retry_nxt;
  logic          w_drop;
  logic          w_link_ok;
  logic          w_timer_en;
  logic          w_timer_clr;
  logic          w_timer_tc;
  logic [TW-1:0] w_tc_val;

  assign w_link_ok = all_ones(CHNL_MAX'(sl_tx_transfer_en), TOTAL_CHNL_NUM) &
                     all_ones(CHNL_MAX'(sl_rx_transfer_en), TOTAL_CHNL_NUM);

  // One timer serves both the reset hold and the calibration window; it
  // restarts from zero whenever the state changes.
  assign w_timer_en  = (r_state == HOLD_RST) || (r_state == CALIB);
  assign w_timer_clr = (w_state_nxt != r_state);
  assign w_tc_val    = (r_state == HOLD_RST) ? C_HOLD_LAST : C_CALIB_LAST;

  aib_cycle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_timer_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (w_timer_en),
    .tc_val   (w_tc_val),
    .tc_hit   (w_timer_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= OFF;
    else        r_state <= w_state_nxt;
  end

  // Next-state, retry and drop decisions; link_en low overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = retry_cnt;
    w_drop      = 1'b0;
    if (!link_en) begin
      w_state_nxt = OFF;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        OFF: begin
          w_state_nxt = HOLD_RST;
          w_retry_nxt = '0;
        end
        HOLD_RST: begin
          if (w_timer_tc) w_state_nxt = CALIB;
        end
        CALIB: begin
          // Success is checked first so it wins over a same-cycle timeout.
          if (calib_done_i && w_link_ok) begin
            w_state_nxt = UP;
          end else if (w_timer_tc) begin
            if (retry_cnt == C_MAX_RETRY) begin
              w_state_nxt = FAIL;
            end else begin
              w_state_nxt = HOLD_RST;
              w_retry_nxt = retry_cnt + 1'b1;
            end
          end
        end
        UP: begin
          if (!w_link_ok) begin
            w_state_nxt = HOLD_RST;
            w_retry_nxt = '0;
            w_drop      = 1'b1;
          end else if (recal_req_i) begin
            w_state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (!w_link_ok) begin
            w_state_nxt = HOLD_RST;
            w_retry_nxt = '0;
            w_drop      = 1'b1;
          end else if (axi_idle_i) begin
            w_state_nxt = HOLD_RST;
            w_retry_nxt = '0;
          end
        end
        FAIL: begin
          w_state_nxt = FAIL;
        end
        default: begin
          w_state_nxt = OFF;
          w_retry_nxt = '0;
        end
      endcase
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calib_rstn_o <= 1'b0;
      axi_gate_o   <= 1'b0;
      link_up      <= 1'b0;
      link_fail    <= 1'b0;
      retry_cnt    <= '0;
      drop_cnt     <= '0;
    end else begin
      calib_rstn_o <= (w_state_nxt == CALIB) || (w_state_nxt == UP) ||
                      (w_state_nxt == DRAIN);
      axi_gate_o   <= (w_state_nxt == UP);
      link_up      <= (w_state_nxt == UP) || (w_state_nxt == DRAIN);
      link_fail    <= (w_state_nxt == FAIL);
      retry_cnt    <= w_retry_nxt;
      if (w_drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule : aib_link_supervisor
`default_nettype wire

// File: tb/tb_aib_link_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_aib_link_supervisor
// Description : Directed self-checking bench for aib_link_supervisor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aib_link_supervisor;

  localparam int N = 24;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         link_en = 1'b0;
  logic         recal_req_i = 1'b0;
  logic         calib_done_i = 1'b0;
  logic [N-1:0] sl_tx_transfer_en = '0;
  logic [N-1:0] sl_rx_transfer_en = '0;
  logic         axi_idle_i = 1'b1;
  logic         calib_rstn_o;
  logic         axi_gate_o;
  logic         link_up;
  logic         link_fail;
  logic [1:0]   retry_cnt;
  logic [7:0]   drop_cnt;

  int checks = 0;
  int errors = 0;

  aib_link_supervisor #(
    .TOTAL_CHNL_NUM  (N),
    .TIMEOUT_CYCLES  (64),
    .RST_HOLD_CYCLES (4),
    .MAX_RETRY       (2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .link_en           (link_en),
    .recal_req_i       (recal_req_i),
    .calib_done_i      (calib_done_i),
    .sl_tx_transfer_en (sl_tx_transfer_en),
    .sl_rx_transfer_en (sl_rx_transfer_en),
    .axi_idle_i        (axi_idle_i),
    .calib_rstn_o      (calib_rstn_o),
    .axi_gate_o        (axi_gate_o),
    .link_up           (link_up),
    .link_fail         (link_fail),
    .retry_cnt         (retry_cnt),
    .drop_cnt          (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state
    step(2);
    chk("rst_calib_rstn", calib_rstn_o, 0);
    chk("rst_gate",       axi_gate_o,   0);
    chk("rst_link_up",    link_up,      0);
    chk("rst_link_fail",  link_fail,    0);
    chk("rst_retry",      retry_cnt,    0);
    chk("rst_drop",       drop_cnt,     0);
    rst_n = 1'b1;
    step(1);
    chk("off_calib_rstn", calib_rstn_o, 0);

    // ---------------- nominal bring-up
    sl_tx_transfer_en = '1;
    sl_rx_transfer_en = '1;
    link_en = 1'b1;
    step(4);
    chk("nom_hold4_rstn", calib_rstn_o, 0);
    step(1);
    chk("nom_calib_rstn", calib_rstn_o, 1);
    chk("nom_calib_up",   link_up,      0);
    step(9);
    chk("nom_pre_up",     link_up,      0);
    calib_done_i = 1'b1;
    step(1);
    chk("nom_up",         link_up,      1);
    chk("nom_gate",       axi_gate_o,   1);
    chk("nom_retry",      retry_cnt,    0);

    // ---------------- link drop in UP
    sl_rx_transfer_en[5] = 1'b0;
    step(1);
    chk("drop_gate",      axi_gate_o,   0);
    chk("drop_up",        link_up,      0);
    chk("drop_rstn",      calib_rstn_o, 0);
    chk("drop_cnt1",      drop_cnt,     1);
    sl_rx_transfer_en = '1;
    step(4);
    chk("drop_calib",     calib_rstn_o, 1);
    step(1);
    chk("drop_reup",      link_up,      1);

    // ---------------- graceful recalibration
    axi_idle_i  = 1'b0;
    recal_req_i = 1'b1;
    step(1);
    recal_req_i = 1'b0;
    chk("drain_gate",     axi_gate_o,   0);
    chk("drain_up",       link_up,      1);
    step(6);
    chk("drain_gate7",    axi_gate_o,   0);
    chk("drain_up7",      link_up,      1);
    axi_idle_i = 1'b1;
    step(1);
    chk("drain_exit_up",  link_up,      0);
    chk("drain_exit_rst", calib_rstn_o, 0);
    chk("drain_drop",     drop_cnt,     1);
    step(4);
    step(1);
    chk("recal_reup",     link_up,      1);

    // recal and drop in the same cycle
    recal_req_i = 1'b1;
    sl_rx_transfer_en[0] = 1'b0;
    step(1);
    recal_req_i = 1'b0;
    sl_rx_transfer_en = '1;
    chk("rd_up",          link_up,      0);
    chk("rd_rstn",        calib_rstn_o, 0);
    chk("rd_drop",        drop_cnt,     2);
    step(5);
    chk("rd_reup",        link_up,      1);

    // ---------------- timeout / retry / fail
    link_en = 1'b0;
    step(1);
    chk("off_up",         link_up,      0);
    calib_done_i = 1'b0;
    link_en = 1'b1;
    step(5);
    chk("to_calib1",      calib_rstn_o, 1);
    step(63);
    chk("to_calib1_end",  calib_rstn_o, 1);
    chk("to_retry0",      retry_cnt,    0);
    step(1);
    chk("to_hold1",       calib_rstn_o, 0);
    chk("to_retry1",      retry_cnt,    1);
    step(4);
    chk("to_calib2",      calib_rstn_o, 1);
    step(63);
    step(1);
    chk("to_retry2",      retry_cnt,    2);
    chk("to_hold2",       calib_rstn_o, 0);
    step(4);
    step(63);
    chk("to_nofail_yet",  link_fail,    0);
    step(1);
    chk("to_fail",        link_fail,    1);
    chk("to_fail_rstn",   calib_rstn_o, 0);
    step(5);
    chk("to_fail_hold",   link_fail,    1);
    link_en = 1'b0;
    step(1);
    chk("to_off_fail",    link_fail,    0);
    chk("to_off_retry",   retry_cnt,    0);

    // ---------------- success and timeout in the same cycle
    link_en = 1'b1;
    step(5);
    step(63);
    step(1);
    chk("sim_retry1",     retry_cnt,    1);
    step(4);
    step(63);
    calib_done_i = 1'b1;
    step(1);
    chk("sim_up",         link_up,      1);
    chk("sim_retry",      retry_cnt,    1);
    chk("sim_fail",       link_fail,    0);

    // drop clears retry count
    sl_tx_transfer_en[3] = 1'b0;
    step(1);
    sl_tx_transfer_en = '1;
    chk("sim_drop_retry", retry_cnt,    0);
    chk("sim_drop_cnt",   drop_cnt,     3);

    // ---------------- asynchronous reset mid-calibration
    calib_done_i = 1'b0;
    step(4);
    chk("ar_calib",       calib_rstn_o, 1);
    step(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_rstn",        calib_rstn_o, 0);
    chk("ar_drop",        drop_cnt,     0);
    chk("ar_up",          link_up,      0);
    chk("ar_gate",        axi_gate_o,   0);
    #2;
    rst_n = 1'b1;

    // ---------------- drop counter saturation
    calib_done_i = 1'b1;
    step(5);
    step(1);
    chk("sat_up",         link_up,      1);
    for (int i = 0; i < 300; i++) begin
      sl_rx_transfer_en[5] = 1'b0;
      step(1);
      sl_rx_transfer_en = '1;
      step(5);
      if (i == 0) chk("sat_first", drop_cnt, 1);
    end
    chk("sat_drop",       drop_cnt,     255);
    chk("sat_up_end",     link_up,      1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_aib_link_supervisor
`default_nettype wire
